// File: rtl/icache_fetch_ctrl.sv
// ============================================================================
// Module   : icache_fetch_ctrl
// Brief    : Direct-mapped instruction cache controller, 4-word lines,
//            block refill from instruction memory.
// Option   : ICACHE_STATS_EN adds hit_count/miss_count outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_fetch_ctrl #(
  parameter int NUM_LINES = 8,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_valid,
  input  logic              flush,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [31:0]       mem_data_0,
  input  logic [31:0]       mem_data_1,
  input  logic [31:0]       mem_data_2,
  input  logic [31:0]       mem_data_3
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - 4 - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MISS = 2'd1,
    S_FILL = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic [ADDR_W-3:0]      pc_cap_q, pc_cap_d;
  logic                   flush_pend_q, flush_pend_d;
  logic [31:0]            instr_q, instr_d;
  logic                   instr_valid_q, instr_valid_d;
  logic                   stall_q, stall_d;
  logic                   mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;

  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [31:0]            data_q [NUM_LINES][4];

  logic [1:0]             w_off, w_cap_off;
  logic [IDX_W-1:0]       w_idx, w_cap_idx;
  logic [TAG_W-1:0]       w_tag, w_cap_tag;
  logic                   w_hit, w_fill, w_hit_inc, w_miss_inc;
  logic [31:0]            w_hit_word, w_fill_word;
  logic                   w_unused_ok;

  assign w_off       = pc[3:2];
  assign w_idx       = pc[4+IDX_W-1:4];
  assign w_tag       = pc[ADDR_W-1:4+IDX_W];
  assign w_cap_off   = pc_cap_q[1:0];
  assign w_cap_idx   = pc_cap_q[IDX_W+1:2];
  assign w_cap_tag   = pc_cap_q[ADDR_W-3:IDX_W+2];
  assign w_unused_ok = &{1'b0, pc[1:0]};

  assign w_hit      = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
  assign w_hit_word = data_q[w_idx][w_off];
  assign w_fill     = (state_q == S_MISS) && mem_ready;

  always_comb begin
    w_fill_word = mem_data_0;
    case (w_cap_off)
      2'd1:    w_fill_word = mem_data_1;
      2'd2:    w_fill_word = mem_data_2;
      2'd3:    w_fill_word = mem_data_3;
      default: w_fill_word = mem_data_0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    pc_cap_d      = pc_cap_q;
    flush_pend_d  = flush_pend_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    stall_d       = stall_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    w_hit_inc     = 1'b0;
    w_miss_inc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A flush in the same cycle as a fetch forces that fetch to miss.
        if (pc_valid) begin
          if (w_hit && !flush) begin
            instr_d       = w_hit_word;
            instr_valid_d = 1'b1;
            w_hit_inc     = 1'b1;
          end else begin
            pc_cap_d   = pc[ADDR_W-1:2];
            mem_addr_d = {pc[ADDR_W-1:4], 4'b0000};
            mem_req_d  = 1'b1;
            stall_d    = 1'b1;
            state_d    = S_MISS;
            w_miss_inc = 1'b1;
          end
        end
        if (flush) valid_d = '0;
      end
      S_MISS: begin
        if (flush) flush_pend_d = 1'b1;
        if (mem_ready) begin
          valid_d[w_cap_idx] = 1'b1;
          instr_d            = w_fill_word;
          instr_valid_d      = 1'b1;
          stall_d            = 1'b0;
          mem_req_d          = 1'b0;
          state_d            = S_FILL;
        end
      end
      S_FILL: begin
        // Deferred flush takes effect on the way back to IDLE.
        if (flush_pend_q || flush) begin
          valid_d      = '0;
          flush_pend_d = 1'b0;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      valid_q       <= '0;
      pc_cap_q      <= '0;
      flush_pend_q  <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      stall_q       <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      pc_cap_q      <= pc_cap_d;
      flush_pend_q  <= flush_pend_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      stall_q       <= stall_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      tag_q[w_cap_idx]     <= w_cap_tag;
      data_q[w_cap_idx][0] <= mem_data_0;
      data_q[w_cap_idx][1] <= mem_data_1;
      data_q[w_cap_idx][2] <= mem_data_2;
      data_q[w_cap_idx][3] <= mem_data_3;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign stall       = stall_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q + {31'd0, w_hit_inc};
    miss_count_d = miss_count_q + {31'd0, w_miss_inc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  logic w_unused_stats;
  assign w_unused_stats = &{1'b0, w_hit_inc, w_miss_inc};
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_fetch_ctrl.sv
// ============================================================================
// Module   : tb_icache_fetch_ctrl
// Brief    : Directed self-checking bench for icache_fetch_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data_0, mem_data_1, mem_data_2, mem_data_3;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  icache_fetch_ctrl #(.NUM_LINES(8), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .flush       (flush),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_data_0  (mem_data_0),
    .mem_data_1  (mem_data_1),
    .mem_data_2  (mem_data_2),
    .mem_data_3  (mem_data_3)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word i of the line holding addr: bytes are numbered by their own low address.
  function automatic logic [31:0] line_word(input logic [31:0] addr, input int i);
    logic [7:0] b;
    b = (addr[7:0] & 8'hF0) + 8'(4 * i);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic do_hit(input logic [31:0] addr, input logic [31:0] exp);
    pc       = addr;
    pc_valid = 1'b1;
    tick();
    check("hit_valid", {31'd0, instr_valid}, 32'd1);
    check("hit_instr", instr, exp);
    check("hit_no_req", {31'd0, mem_req}, 32'd0);
  endtask

  task automatic do_miss(input logic [31:0] addr, input int wait_cyc, input logic [31:0] exp,
                         input bit flush_with_req, input bit flush_mid);
    pc       = addr;
    pc_valid = 1'b1;
    flush    = flush_with_req;
    tick();
    pc_valid = 1'b0;
    flush    = 1'b0;
    pc       = 32'hDEAD_BEE0;
    check("miss_req", {31'd0, mem_req}, 32'd1);
    check("miss_addr", mem_addr, {addr[31:4], 4'b0000});
    check("miss_stall", {31'd0, stall}, 32'd1);
    check("miss_ivalid", {31'd0, instr_valid}, 32'd0);
    for (int k = 1; k < wait_cyc; k++) begin
      pc_valid = (k == 2);
      flush    = flush_mid && (k == 1);
      tick();
      pc_valid = 1'b0;
      flush    = 1'b0;
      check("hold_req", {31'd0, mem_req}, 32'd1);
      check("hold_addr", mem_addr, {addr[31:4], 4'b0000});
      check("hold_stall", {31'd0, stall}, 32'd1);
    end
    mem_ready  = 1'b1;
    mem_data_0 = line_word(addr, 0);
    mem_data_1 = line_word(addr, 1);
    mem_data_2 = line_word(addr, 2);
    mem_data_3 = line_word(addr, 3);
    tick();
    mem_ready  = 1'b0;
    mem_data_0 = 32'hX;
    check("fill_valid", {31'd0, instr_valid}, 32'd1);
    check("fill_instr", instr, exp);
    check("fill_stall", {31'd0, stall}, 32'd0);
    check("fill_req", {31'd0, mem_req}, 32'd0);
    tick();
    check("idle_ivalid", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    pc         = '0;
    pc_valid   = 1'b0;
    flush      = 1'b0;
    mem_ready  = 1'b0;
    mem_data_0 = '0;
    mem_data_1 = '0;
    mem_data_2 = '0;
    mem_data_3 = '0;
    #22;
    check("rst_instr", instr, 32'h0);
    check("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Cold miss, memory answers on the 5th cycle of mem_req.
    do_miss(32'h0000_0008, 5, 32'h0B0A_0908, 1'b0, 1'b0);

    // Back-to-back hits on the freshly filled line.
    do_hit(32'h0000_000C, 32'h0F0E_0D0C);
    do_hit(32'h0000_0000, 32'h0302_0100);
    pc_valid = 1'b0;
    tick();
    check("hit_drop", {31'd0, instr_valid}, 32'd0);

    // Conflict on index 0: 0x80 evicts 0x00, then 0x00 evicts 0x80.
    do_miss(32'h0000_0080, 2, 32'h8382_8180, 1'b0, 1'b0);
    do_miss(32'h0000_0000, 1, 32'h0302_0100, 1'b0, 1'b0);
    do_hit(32'h0000_0004, 32'h0706_0504);
    pc_valid = 1'b0;

    // Flush in IDLE, then refetch misses.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    do_miss(32'h0000_0004, 2, 32'h0706_0504, 1'b0, 1'b0);

    // Flush with a fetch in the same cycle: the line is valid but must miss.
    do_miss(32'h0000_0004, 1, 32'h0706_0504, 1'b1, 1'b0);

    // Flush during MISS: instruction still returned, line gone afterwards.
    do_miss(32'h0000_0034, 3, 32'h3736_3534, 1'b0, 1'b1);
    do_miss(32'h0000_0034, 1, 32'h3736_3534, 1'b0, 1'b0);

    // Reset during a miss, checked before any clock edge.
    pc       = 32'h0000_0010;
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    check("pre_rst_req", {31'd0, mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req", {31'd0, mem_req}, 32'd0);
    check("arst_stall", {31'd0, stall}, 32'd0);
    check("arst_ivalid", {31'd0, instr_valid}, 32'd0);
    check("arst_instr", instr, 32'h0);
    tick();
    rst_n      = 1'b1;
    mem_ready  = 1'b1;
    mem_data_0 = 32'hBAD0_0000;
    mem_data_1 = 32'hBAD0_0001;
    mem_data_2 = 32'hBAD0_0002;
    mem_data_3 = 32'hBAD0_0003;
    tick();
    mem_ready = 1'b0;
    check("stray_ivalid", {31'd0, instr_valid}, 32'd0);
    check("stray_req", {31'd0, mem_req}, 32'd0);
    tick();
    check("stray_ivalid2", {31'd0, instr_valid}, 32'd0);
    do_miss(32'h0000_0010, 2, 32'h1312_1110, 1'b0, 1'b0);
    do_miss(32'h0000_0000, 1, 32'h0302_0100, 1'b0, 1'b0);
    do_hit(32'h0000_0018, 32'h1B1A_1918);
    pc_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
